// File: rtl/decode_scan.sv
// decode_scan: registered W-to-2^W one-hot decoder with enable and a
// prescaled up/down scan sequencer (load, hold, wrap pulse).
// Typical use is digit/row select for multiplexed displays, or a direct
// select stage in front of a register file or mux.
module decode_scan #(
    parameter int W   = 3,
    parameter int DIV = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic                 load,
    input  logic [W-1:0]         x,
    output logic [(1<<W)-1:0]    y,
    output logic [W-1:0]         idx,
    output logic                 wrap
);

    localparam int N  = 1 << W;
    // The prescaler needs at least one bit even when DIV=1, where it is
    // pinned at zero and every enabled cycle is a step.
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
    localparam logic [W-1:0]  IMAX = W'(N - 1);

    typedef enum logic [1:0] {
        M_DIRECT    = 2'b00,
        M_SCAN_UP   = 2'b01,
        M_SCAN_DOWN = 2'b10,
        M_HOLD      = 2'b11
    } mode_e;

    mode_e          mode_q;
    logic [PW-1:0]  pcnt;
    logic [W-1:0]   idx_up;
    logic [W-1:0]   idx_dn;
    logic [W-1:0]   idx_step;
    logic           step_wrap;

    // Neighbouring indices; modulo-N arithmetic falls out of the W-bit width.
    always_comb begin
        mode_q   = mode_e'(mode);
        idx_up   = idx + W'(1);
        idx_dn   = idx - W'(1);
        idx_step = (mode_q == M_SCAN_DOWN) ? idx_dn : idx_up;
        step_wrap = (mode_q == M_SCAN_DOWN) ? (idx == '0) : (idx == IMAX);
    end

    function automatic logic [N-1:0] onehot(input logic [W-1:0] v);
        onehot = {{(N-1){1'b0}}, 1'b1} << v;
    endfunction

    // Index, prescaler and registered outputs; y always equals onehot(idx)
    // when enabled, so it can never go multi-hot.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            pcnt <= '0;
            y    <= '0;
            wrap <= 1'b0;
        end else if (!en) begin
            y    <= '0;
            pcnt <= '0;
            wrap <= 1'b0;
        end else begin
            case (mode_q)
                M_DIRECT: begin
                    idx  <= x;
                    y    <= onehot(x);
                    pcnt <= '0;
                    wrap <= 1'b0;
                end
                M_SCAN_UP, M_SCAN_DOWN: begin
                    if (load) begin
                        // A load wins over a step due in the same cycle.
                        idx  <= x;
                        y    <= onehot(x);
                        pcnt <= '0;
                        wrap <= 1'b0;
                    end else if (pcnt == PMAX) begin
                        idx  <= idx_step;
                        y    <= onehot(idx_step);
                        pcnt <= '0;
                        wrap <= step_wrap;
                    end else begin
                        y    <= onehot(idx);
                        pcnt <= pcnt + PW'(1);
                        wrap <= 1'b0;
                    end
                end
                default: begin
                    // HOLD keeps pcnt so a scan resumes mid-period.
                    y    <= onehot(idx);
                    wrap <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_decode_scan.sv
// tb_decode_scan: four decode_scan instances with different W/DIV share
// one stimulus stream. A behavioural model of each instance pushes the
// expected {wrap, idx, y} into exp_q when inputs are driven; entries are
// popped and compared one step after the clock edge.
module tb_decode_scan;

    logic       clk;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic       load;
    logic [7:0] x;

    logic [3:0] y_a;  logic [1:0] idx_a;  logic wrap_a;  // W=2 DIV=3
    logic [7:0] y_b;  logic [2:0] idx_b;  logic wrap_b;  // W=3 DIV=4
    logic [3:0] y_c;  logic [1:0] idx_c;  logic wrap_c;  // W=2 DIV=2
    logic [1:0] y_d;  logic [0:0] idx_d;  logic wrap_d;  // W=1 DIV=1

    decode_scan #(.W(2), .DIV(3)) u_a (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .x(x[1:0]),
        .y(y_a), .idx(idx_a), .wrap(wrap_a));
    decode_scan #(.W(3), .DIV(4)) u_b (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .x(x[2:0]),
        .y(y_b), .idx(idx_b), .wrap(wrap_b));
    decode_scan #(.W(2), .DIV(2)) u_c (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .x(x[1:0]),
        .y(y_c), .idx(idx_c), .wrap(wrap_c));
    decode_scan #(.W(1), .DIV(1)) u_d (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .load(load), .x(x[0:0]),
        .y(y_d), .idx(idx_d), .wrap(wrap_d));

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [16:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    int pw[4]   = '{2, 3, 2, 1};
    int pdiv[4] = '{3, 4, 2, 1};
    int m_idx[4];
    int m_p[4];

    function automatic logic [16:0] obs(input int k);
        case (k)
            0:       return {wrap_a, 6'd0, idx_a, 4'd0, y_a};
            1:       return {wrap_b, 5'd0, idx_b, y_b};
            2:       return {wrap_c, 6'd0, idx_c, 4'd0, y_c};
            default: return {wrap_d, 7'd0, idx_d, 6'd0, y_d};
        endcase
    endfunction

    task automatic check(input string tag, input logic [16:0] o, input logic [16:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Next-state model for every instance, driven by the current inputs.
    task automatic model_step();
        int n, mask, old, yv, wv;
        for (int k = 0; k < 4; k++) begin
            n = 1 << pw[k];
            mask = n - 1;
            yv = 0;
            wv = 0;
            if (rst) begin
                m_idx[k] = 0;
                m_p[k] = 0;
            end else if (!en) begin
                m_p[k] = 0;
            end else if (mode == 2'b00 || ((mode == 2'b01 || mode == 2'b10) && load)) begin
                m_idx[k] = int'(x) & mask;
                m_p[k] = 0;
                yv = 1 << m_idx[k];
            end else if (mode == 2'b11) begin
                yv = 1 << m_idx[k];
            end else if (m_p[k] == pdiv[k] - 1) begin
                old = m_idx[k];
                m_p[k] = 0;
                if (mode == 2'b01) begin
                    m_idx[k] = (old + 1) & mask;
                    wv = (old == n - 1) ? 1 : 0;
                end else begin
                    m_idx[k] = (old + n - 1) & mask;
                    wv = (old == 0) ? 1 : 0;
                end
                yv = 1 << m_idx[k];
            end else begin
                m_p[k] = m_p[k] + 1;
                yv = 1 << m_idx[k];
            end
            exp_q.push_back({wv[0], 8'(m_idx[k]), 8'(yv)});
        end
    endtask

    // Push expectations for the driven inputs, clock once, compare.
    task automatic cycle(input string tag);
        logic [16:0] e;
        model_step();
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            check($sformatf("%s/u%0d", tag, k), obs(k), e);
        end
    endtask

    task automatic drive(input logic r, input logic e, input logic [1:0] m,
                         input logic l, input logic [7:0] xv);
        rst = r; en = e; mode = m; load = l; x = xv;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        drive(1'b1, 1'b1, 2'b01, 1'b0, 8'd0);
        for (int k = 0; k < 4; k++) begin
            m_idx[k] = 0;
            m_p[k] = 0;
        end
        @(posedge clk);
        #1;

        // Reset dominates en/mode.
        cycle("reset0");
        cycle("reset1");
        check("reset_y_a", {13'd0, y_a}, 17'd0);
        check("reset_wrap_a", {16'd0, wrap_a}, 17'd0);

        // Release into SCAN_UP; first cycle shows index 0, full wrap follows.
        drive(1'b0, 1'b1, 2'b01, 1'b0, 8'd0);
        cycle("release");
        check("release_y_a", {13'd0, y_a}, 17'b0001);
        for (int i = 0; i < 13; i++) cycle($sformatf("scan_up%0d", i));

        // DIRECT sweep: y follows x one cycle later.
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 2'b00, 1'b0, 8'(i));
            cycle($sformatf("direct%0d", i));
        end
        check("direct_y_b_last", {9'd0, y_b}, 17'h80);
        drive(1'b0, 1'b0, 2'b00, 1'b0, 8'd2);
        cycle("disable");
        check("disable_y_b", {9'd0, y_b}, 17'd0);
        check("disable_idx_b", {14'd0, idx_b}, 17'd7);

        // SCAN_DOWN with a one-cycle load of 1, then wrap through 0.
        drive(1'b0, 1'b1, 2'b10, 1'b1, 8'd1);
        cycle("load");
        drive(1'b0, 1'b1, 2'b10, 1'b0, 8'd3);
        for (int i = 0; i < 10; i++) cycle($sformatf("scan_dn%0d", i));

        // Load arriving when a step is due must win.
        drive(1'b0, 1'b1, 2'b01, 1'b1, 8'd2);
        cycle("load_vs_step");

        // HOLD mid-count, resume, then an en=0 pulse clears the prescaler.
        drive(1'b1, 1'b1, 2'b01, 1'b0, 8'd0);
        cycle("hold_rst");
        drive(1'b0, 1'b1, 2'b01, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) cycle($sformatf("pre_hold%0d", i));
        drive(1'b0, 1'b1, 2'b11, 1'b0, 8'd3);
        for (int i = 0; i < 5; i++) cycle($sformatf("hold%0d", i));
        drive(1'b0, 1'b1, 2'b01, 1'b0, 8'd0);
        for (int i = 0; i < 3; i++) cycle($sformatf("resume%0d", i));
        drive(1'b0, 1'b0, 2'b01, 1'b0, 8'd0);
        cycle("en_pulse");
        drive(1'b0, 1'b1, 2'b01, 1'b0, 8'd0);
        for (int i = 0; i < 5; i++) cycle($sformatf("reenable%0d", i));

        // Switching SCAN_UP -> SCAN_DOWN keeps the prescaler.
        drive(1'b0, 1'b1, 2'b10, 1'b0, 8'd0);
        for (int i = 0; i < 4; i++) cycle($sformatf("dir_swap%0d", i));

        // Random stress with one-hot invariant on the W=1 and W=2 instances.
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) != 0),
                  2'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
                  8'($urandom_range(0, 255)));
            cycle($sformatf("rand%0d", i));
            if (en && !rst) begin
                check($sformatf("onehot_a%0d", i), {13'd0, y_a}, {13'd0, 4'(4'b0001 << idx_a)});
                check($sformatf("onehot_d%0d", i), {15'd0, y_d}, {15'd0, 2'(2'b01 << idx_d)});
            end else begin
                check($sformatf("zero_a%0d", i), {13'd0, y_a}, 17'd0);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
